// File: rtl/scroll_selector.sv
// Scroll position generator: auto prescaler or debounced manual STEP advances SEL through 0..SEL_MAX.
// SEL/TICK/WRAP are registered (advance visible one edge after it is decided); no backpressure, nothing is ever stalled.
module scroll_selector #(
    parameter int DIV     = 25_000_000,
    parameter int DEB     = 500_000,
    parameter int SEL_W   = 3,
    parameter int SEL_MAX = 7
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             DIR,
    input  logic             MODE,
    input  logic             STEP,
    output logic [SEL_W-1:0] SEL,
    output logic             TICK,
    output logic             WRAP
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [PW-1:0]    P_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(DEB - 1);
    localparam logic [SEL_W-1:0] S_LAST = SEL_W'(SEL_MAX);

    logic [PW-1:0]    pcnt;
    logic [DW-1:0]    dcnt;
    logic             s1;
    logic             s2;
    logic             db;
    logic             auto_adv;
    logic             db_flip;
    logic             man_adv;
    logic             adv;
    logic             wrap_taken;
    logic [SEL_W-1:0] sel_nxt;

    always_comb begin
        auto_adv   = ~MODE & EN & (pcnt == P_LAST);
        db_flip    = (s2 != db) && (dcnt == D_LAST);
        // Only an accepted press (new level 1) counts, and only in manual mode.
        man_adv    = MODE & db_flip & s2;
        adv        = auto_adv | man_adv;
        sel_nxt    = SEL;
        wrap_taken = 1'b0;
        if (DIR) begin
            if (SEL == '0) begin
                sel_nxt    = S_LAST;
                wrap_taken = 1'b1;
            end else begin
                sel_nxt = SEL - SEL_W'(1);
            end
        end else begin
            if (SEL == S_LAST) begin
                sel_nxt    = '0;
                wrap_taken = 1'b1;
            end else begin
                sel_nxt = SEL + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            pcnt <= '0;
            dcnt <= '0;
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            SEL  <= '0;
            TICK <= 1'b0;
            WRAP <= 1'b0;
        end else begin
            if (MODE) begin
                pcnt <= '0;
            end else if (EN) begin
                pcnt <= (pcnt == P_LAST) ? '0 : pcnt + PW'(1);
            end

            s1 <= STEP;
            s2 <= s1;

            if (s2 == db) begin
                dcnt <= '0;
            end else if (db_flip) begin
                db   <= s2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end

            if (adv) begin
                SEL <= sel_nxt;
            end
            TICK <= adv;
            WRAP <= adv & wrap_taken;
        end
    end

endmodule
